// File: rtl/spi_bus_master_if.sv
// rtl/spi_bus_master_if.sv - Host-side request/data and SPI pin bundle for spi_bus_master
//
// Purpose: groups the transaction request, byte streams, status and SPI pins.
// Signals:
//   start, addr[7:0], nbytes[7:0]     transaction request, address, data byte count
//   tx_data[7:0], tx_valid, tx_ready  outbound data byte handshake
//   rx_data[7:0], rx_valid            inbound data byte and one-cycle strobe
//   busy, done                        transaction status and completion pulse
//   sclk, mosi, miso, ncs             SPI host port (ncs active low)
// Modports: master = the SPI master block, slave = host/bench side.
interface spi_bus_master_if;
    logic       start;
    logic [7:0] addr;
    logic [7:0] nbytes;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ncs;

    modport master (
        input  start, addr, nbytes, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, ncs
    );

    modport slave (
        output start, addr, nbytes, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, ncs
    );
endinterface

// File: rtl/spi_bus_master.sv
// rtl/spi_bus_master.sv - SPI mode-0 master: address byte then NBYTES streamed data bytes
//
// Purpose: on START, asserts ncs, sends ADDR then NBYTES data bytes MSB-first,
// capturing MISO into RX_DATA for every data byte, then honours hold and gap
// times on ncs before pulsing DONE.
// Ports:
//   CLK   clock, all logic on rising edge
//   RST   synchronous active-high reset
//   bus   spi_bus_master_if.master (request, tx/rx byte streams, status, SPI pins)
// Parameters: CLK_DIV (SCLK half period, 4..255), CS_SETUP, CS_HOLD, CS_GAP (CLK cycles).
module spi_bus_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    spi_bus_master_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        LOW   = 3'd3,
        HIGH  = 3'd4,
        HOLD  = 3'd5,
        GAP   = 3'd6
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

    state_t      state;
    state_t      state_n;
    logic        cnt_last;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  rem;
    logic [7:0]  addr_q;
    logic [7:0]  rx_data_q;
    logic        is_addr;
    logic        rx_valid_q;
    logic        done_q;
    logic        mosi_q;
    logic        sclk_q;
    logic        ncs_q;
    logic        busy_q;
    logic        tx_ready_q;
    logic        miso_s1;
    logic        miso_s2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_last = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_n = SETUP;
            end
            SETUP: begin
                cnt_last = (cnt == SETUP_LAST);
                if (cnt_last) state_n = LOW;
            end
            LOAD: begin
                if (bus.tx_valid) state_n = LOW;
            end
            LOW: begin
                cnt_last = (cnt == DIV_LAST);
                if (cnt_last) state_n = HIGH;
            end
            HIGH: begin
                cnt_last = (cnt == DIV_LAST);
                if (cnt_last) begin
                    if (bit_cnt == 3'd7) state_n = (rem != 8'd0) ? LOAD : HOLD;
                    else                 state_n = LOW;
                end
            end
            HOLD: begin
                cnt_last = (cnt == HOLD_LAST);
                if (cnt_last) state_n = GAP;
            end
            GAP: begin
                cnt_last = (cnt == GAP_LAST);
                if (cnt_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= 16'd0;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            rem        <= 8'd0;
            addr_q     <= 8'd0;
            rx_data_q  <= 8'd0;
            is_addr    <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            miso_s1    <= 1'b0;
            miso_s2    <= 1'b0;
        end else begin
            miso_s1    <= bus.miso;
            miso_s2    <= miso_s1;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            // Every phase times itself from zero on entry.
            cnt        <= (state_n != state) ? 16'd0 : cnt + 16'd1;

            // Pin outputs follow the state being entered so they line up with it.
            sclk_q     <= (state_n == HIGH);
            ncs_q      <= (state_n == IDLE) || (state_n == GAP);
            busy_q     <= (state_n != IDLE);
            tx_ready_q <= (state_n == LOAD);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q  <= bus.addr;
                        rem     <= bus.nbytes;
                        is_addr <= 1'b1;
                        bit_cnt <= 3'd0;
                    end
                end
                SETUP: begin
                    if (cnt_last) begin
                        shift  <= addr_q;
                        mosi_q <= addr_q[7];
                    end
                end
                LOAD: begin
                    if (bus.tx_valid) begin
                        shift   <= bus.tx_data;
                        mosi_q  <= bus.tx_data[7];
                        rem     <= rem - 8'd1;
                        is_addr <= 1'b0;
                    end
                end
                LOW: begin
                    // Sample on the SCLK rising edge; MOSI is held separately in
                    // mosi_q so shifting here does not disturb the driven bit.
                    if (cnt_last) shift <= {shift[6:0], miso_s2};
                end
                HIGH: begin
                    if (cnt_last) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (!is_addr) begin
                                rx_data_q  <= shift;
                                rx_valid_q <= 1'b1;
                            end
                        end else begin
                            mosi_q <= shift[7];
                        end
                    end
                end
                GAP: begin
                    if (cnt_last) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.ncs      = ncs_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// tb/tb_spi_bus_master.sv - Directed self-checking bench for spi_bus_master
module tb_spi_bus_master;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    spi_bus_master_if bus ();

    spi_bus_master #(.CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor state, cumulative; the stimulus block compares differences.
    int          rise_cnt = 0, rise_bad = 0, mosi_bad = 0, mosi_same = 0;
    int          ncs_rise = 0, txr_cnt = 0, load_bad = 0, last_load_rise = 0;
    int          done_cnt = 0, rx_cnt = 0, high_run = 0, last_high_run = 0;
    logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ncs = 1'b1;
    logic [63:0] mosi_sr = 64'd0;
    logic [7:0]  rx_log [32];

    // Gateway model inputs, written only by the stimulus block.
    logic [63:0] miso_stream = 64'd0;
    int          miso_base = 0;

    // TX byte source: stimulus appends, driver consumes on handshakes.
    logic [7:0]  tx_mem [16];
    int          tx_wr = 0, tx_idx = 0, stall_at = -1, stall_len = 0, stall_used = 0;
    logic        hs_pend = 1'b0;
    logic        stalling;

    always @(negedge clk) begin
        if (bus.sclk && !prev_sclk) begin
            rise_cnt++;
            mosi_sr = {mosi_sr[62:0], bus.mosi};
            if (bus.ncs) rise_bad++;
        end
        if (bus.mosi !== prev_mosi) begin
            if (bus.sclk) mosi_bad++;
            mosi_same = 0;
        end else begin
            mosi_same++;
        end
        if (bus.sclk && !prev_sclk && mosi_same < 4) mosi_bad++;
        if (bus.ncs && !prev_ncs) ncs_rise++;
        if (bus.ncs) high_run++;
        else begin
            if (prev_ncs) last_high_run = high_run;
            high_run = 0;
        end
        if (bus.tx_ready) begin
            txr_cnt++;
            last_load_rise = rise_cnt;
            if (bus.sclk || bus.ncs) load_bad++;
        end
        if (bus.rx_valid) begin
            rx_log[rx_cnt % 32] = bus.rx_data;
            rx_cnt++;
        end
        if (bus.done) done_cnt++;
        prev_sclk = bus.sclk;
        prev_mosi = bus.mosi;
        prev_ncs  = bus.ncs;
        // Gateway presents the next MISO bit after each rising edge.
        if ((rise_cnt - miso_base) >= 0 && (rise_cnt - miso_base) < 64)
            bus.miso = miso_stream[63 - (rise_cnt - miso_base)];
        else
            bus.miso = 1'b0;
    end

    always @(negedge clk) begin
        if (hs_pend) tx_idx++;
        stalling = (tx_idx == stall_at) && (stall_used < stall_len);
        if (stalling && bus.tx_ready) stall_used++;
        bus.tx_valid = (tx_idx < tx_wr) && !stalling;
        bus.tx_data  = tx_mem[tx_idx % 16];
        hs_pend      = bus.tx_valid && bus.tx_ready;
    end

    int s_rise, s_ncs, s_rbad, s_mbad, s_done, s_txr, s_rx, s_lbad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_rise = rise_cnt; s_ncs = ncs_rise; s_rbad = rise_bad; s_mbad = mosi_bad;
        s_done = done_cnt; s_txr = txr_cnt; s_rx = rx_cnt; s_lbad = load_bad;
    endtask

    task automatic push(input logic [7:0] b);
        tx_mem[tx_wr % 16] = b;
        tx_wr++;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] n);
        miso_base = rise_cnt;
        snap();
        bus.addr   = a;
        bus.nbytes = n;
        bus.start  = 1'b1;
    endtask

    // Cycles counted from the edge that samples START; 0 means timeout.
    task automatic wait_done(input bit drop, output int lat);
        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (i == 1 && drop) bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        @(negedge clk); #1;
    endtask

    int lat;
    bit found;

    initial begin
        bus.start = 1'b0; bus.addr = 8'd0; bus.nbytes = 8'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ncs",      bus.ncs,      1);
        check("rst_sclk",     bus.sclk,     0);
        check("rst_mosi",     bus.mosi,     0);
        check("rst_busy",     bus.busy,     0);
        check("rst_done",     bus.done,     0);
        check("rst_tx_ready", bus.tx_ready, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data",  bus.rx_data,  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write: 0x12 then 0xA5, 0x3C; latency 1+4+192+2+4+8.
        push(8'hA5); push(8'h3C);
        miso_stream = {8'h00, 8'h11, 8'h22, 40'd0};
        launch(8'h12, 8'd2);
        wait_done(1'b1, lat);
        check("wr_latency",   lat, 211);
        check("wr_rises",     rise_cnt - s_rise, 24);
        check("wr_mosi",      {40'd0, mosi_sr[23:0]}, 64'h12A53C);
        check("wr_ncs_rise",  ncs_rise - s_ncs, 1);
        check("wr_rise_ncs",  rise_bad - s_rbad, 0);
        check("wr_mosi_stab", mosi_bad - s_mbad, 0);
        check("wr_done",      done_cnt - s_done, 1);
        check("wr_tx_ready",  txr_cnt - s_txr, 2);
        check("wr_busy_end",  bus.busy, 0);

        // Read: gateway returns 0x5A, 0xC3 after the address byte.
        push(8'h00); push(8'h00);
        miso_stream = {8'hFF, 8'h5A, 8'hC3, 40'd0};
        launch(8'h93, 8'd2);
        wait_done(1'b1, lat);
        check("rd_latency", lat, 211);
        check("rd_rx_cnt",  rx_cnt - s_rx, 2);
        check("rd_rx0",     rx_log[s_rx % 32], 8'h5A);
        check("rd_rx1",     rx_log[(s_rx + 1) % 32], 8'hC3);
        check("rd_rx_hold", bus.rx_data, 8'hC3);
        check("rd_done",    done_cnt - s_done, 1);

        // Stall: second data byte withheld 20 cycles.
        push(8'h81);
        stall_at = tx_wr; stall_len = 20;
        push(8'h7E);
        miso_stream = 64'd0;
        launch(8'h34, 8'd2);
        wait_done(1'b1, lat);
        check("st_latency",   lat, 231);
        check("st_rises",     rise_cnt - s_rise, 24);
        check("st_after",     rise_cnt - last_load_rise, 8);
        check("st_mosi",      {40'd0, mosi_sr[23:0]}, 64'h34817E);
        check("st_tx_ready",  txr_cnt - s_txr, 22);
        check("st_load_pins", load_bad - s_lbad, 0);
        check("st_ncs_rise",  ncs_rise - s_ncs, 1);
        check("st_mosi_stab", mosi_bad - s_mbad, 0);

        // Address only: 1+4+64+4+8.
        launch(8'hC7, 8'd0);
        wait_done(1'b1, lat);
        check("ao_latency",  lat, 81);
        check("ao_rises",    rise_cnt - s_rise, 8);
        check("ao_mosi",     {56'd0, mosi_sr[7:0]}, 64'hC7);
        check("ao_tx_ready", txr_cnt - s_txr, 0);
        check("ao_rx",       rx_cnt - s_rx, 0);
        check("ao_done",     done_cnt - s_done, 1);

        // Reset during bit 3 of the first data byte (12th rising edge).
        push(8'hF0); push(8'h0F);
        launch(8'h55, 8'd2);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.start = 1'b0;
            if (rise_cnt - s_rise == 12) begin
                found = 1'b1;
                break;
            end
        end
        check("rs_reach", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rs_ncs",  bus.ncs,  1);
        check("rs_sclk", bus.sclk, 0);
        check("rs_busy", bus.busy, 0);
        check("rs_done", bus.done, 0);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("rs_no_edges", rise_cnt - s_rise, 12);
        check("rs_no_done",  done_cnt - s_done, 0);

        // Fresh transaction; the unsent 0x0F left by the abort is its data byte.
        launch(8'h66, 8'd1);
        wait_done(1'b1, lat);
        check("rs2_latency", lat, 146);
        check("rs2_rises",   rise_cnt - s_rise, 16);
        check("rs2_mosi",    {48'd0, mosi_sr[15:0]}, 64'h660F);
        check("rs2_done",    done_cnt - s_done, 1);

        // Back to back: START held high across two address-only transactions.
        launch(8'hA1, 8'd0);
        wait_done(1'b0, lat);
        check("bb1_latency",  lat, 81);
        check("bb1_rises",    rise_cnt - s_rise, 8);
        check("bb1_ncs_rise", ncs_rise - s_ncs, 1);
        check("bb1_mosi",     {56'd0, mosi_sr[7:0]}, 64'hA1);
        snap();
        wait_done(1'b1, lat);
        check("bb2_latency", lat, 81);
        check("bb2_rises",   rise_cnt - s_rise, 8);
        check("bb2_gap",     last_high_run >= 8, 1);
        check("bb2_done",    done_cnt - s_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
